// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters,
// with a one-entry registered response buffer per port.
module alu_share_arbiter #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned OP_W    = 4,
    parameter bit          RR_INIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [OP_W-1:0]   r0_op,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic [4:0]        r0_sa,
    output logic              r0_rvalid,
    input  logic              r0_rready,
    output logic [DATA_W-1:0] r0_result,
    output logic              r0_zero,

    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [OP_W-1:0]   r1_op,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    input  logic [4:0]        r1_sa,
    output logic              r1_rvalid,
    input  logic              r1_rready,
    output logic [DATA_W-1:0] r1_result,
    output logic              r1_zero,

    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_input1,
    output logic [DATA_W-1:0] alu_input2,
    output logic [4:0]        alu_sa,
    input  logic [DATA_W-1:0] alu_result,
    output logic              grant_id
);

    logic elig0;
    logic elig1;
    logic grant0;
    logic grant1;
    logic last;

    // A port may only be granted if its response slot is empty or draining this cycle.
    assign elig0 = r0_valid & (~r0_rvalid | r0_rready);
    assign elig1 = r1_valid & (~r1_rvalid | r1_rready);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
            grant0 = last;
            grant1 = ~last;
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
    end

    assign r0_ready = grant0;
    assign r1_ready = grant1;
    assign grant_id = grant1;

    always_comb begin
        alu_op     = '0;
        alu_input1 = '0;
        alu_input2 = '0;
        alu_sa     = '0;
        if (grant0) begin
            alu_op     = r0_op;
            alu_input1 = r0_a;
            alu_input2 = r0_b;
            alu_sa     = r0_sa;
        end else if (grant1) begin
            alu_op     = r1_op;
            alu_input1 = r1_a;
            alu_input2 = r1_b;
            alu_sa     = r1_sa;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= RR_INIT;
        end else if (grant0) begin
            last <= 1'b0;
        end else if (grant1) begin
            last <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_rvalid <= 1'b0;
            r0_result <= '0;
            r0_zero   <= 1'b0;
        end else if (grant0) begin
            r0_rvalid <= 1'b1;
            r0_result <= alu_result;
            r0_zero   <= (alu_result == '0);
        end else if (r0_rready) begin
            r0_rvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_rvalid <= 1'b0;
            r1_result <= '0;
            r1_zero   <= 1'b0;
        end else if (grant1) begin
            r1_rvalid <= 1'b1;
            r1_result <= alu_result;
            r1_zero   <= (alu_result == '0);
        end else if (r1_rready) begin
            r1_rvalid <= 1'b0;
        end
    end

endmodule
